// File: rtl/sync_down_counter.sv
// Loadable synchronous down counter/timer with one-shot and auto-reload modes.
// Optional prescaler enabled by defining SYNC_DOWN_COUNTER_PRESCALE_EN.
module sync_down_counter #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
  logic             tick;

  if (PRESCALE < 1) begin : g_prescale_invalid
    $error("sync_down_counter: PRESCALE must be >= 1");
  end

`ifdef SYNC_DOWN_COUNTER_PRESCALE_EN
  localparam int PRESCALE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_q, pre_d;

  assign tick = (pre_q == PRE_LAST);

  // Prescale phase restarts whenever counting is (re)started, paused or loaded.
  always_comb begin
    pre_d = '0;
    if (load || stop || (start && state_q != RUN)) begin
      pre_d = '0;
    end else if (state_q == RUN && !tick) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else if (stop) begin
      if (state_q == RUN) begin
        state_d = IDLE;
      end
    end else if (start && state_q != RUN) begin
      // Resume from a held non-zero count; otherwise restart from the reload value.
      if (state_q == IDLE && q_q != '0) begin
        state_d = RUN;
      end else if (reload_q != '0) begin
        q_d     = reload_q;
        state_d = RUN;
      end
    end else if (state_q == RUN && tick) begin
      if (q_q > WIDTH'(1)) begin
        q_d = q_q - 1'b1;
      end else if (q_q == WIDTH'(1)) begin
        q_d  = '0;
        tc_d = 1'b1;
      end else if (mode && reload_q != '0) begin
        q_d = reload_q;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign Q    = q_q;
  assign busy = busy_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule
